// File: rtl/vending_pkg.sv
// rtl/vending_pkg.sv - shared constants and state type for the vending datapath
package vending_pkg;

  localparam int CHANGE_W = 5;

  localparam logic [CHANGE_W-1:0] COIN_TEN  = CHANGE_W'(10);
  localparam logic [CHANGE_W-1:0] COIN_FIVE = CHANGE_W'(5);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SELECT,
    ST_WAIT_ACK,
    ST_DONE
  } disp_state_e;

endpackage

// File: rtl/vending_change_dispenser_if.sv
// rtl/vending_change_dispenser_if.sv - request, hopper and inventory signals of the change dispenser
interface vending_change_dispenser_if
  import vending_pkg::*;
#(
  parameter int CNT_W = 4
);

  logic [CHANGE_W-1:0] change;
  logic                change_valid;
  logic                ready;
  logic                coin_ten;
  logic                coin_five;
  logic                coin_ack;
  logic                refill;
  logic                done;
  logic [CHANGE_W-1:0] shortfall;
  logic                err;
  logic [CNT_W-1:0]    tens_left;
  logic [CNT_W-1:0]    fives_left;

  modport slave (
    input  change, change_valid, coin_ack, refill,
    output ready, coin_ten, coin_five, done, shortfall, err, tens_left, fives_left
  );

  modport master (
    output change, change_valid, coin_ack, refill,
    input  ready, coin_ten, coin_five, done, shortfall, err, tens_left, fives_left
  );

endinterface

// File: rtl/vending_coin_store.sv
// rtl/vending_coin_store.sv - 10- and 5-coin inventory down-counters with refill
module vending_coin_store #(
  parameter int INIT_TEN  = 8,
  parameter int INIT_FIVE = 8,
  parameter int CNT_W     = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             refill,
  input  logic             dec_ten,
  input  logic             dec_five,
  output logic [CNT_W-1:0] tens_left,
  output logic [CNT_W-1:0] fives_left,
  output logic             ten_nz,
  output logic             five_nz
);

  logic [CNT_W-1:0] tens_q, tens_d;
  logic [CNT_W-1:0] fives_q, fives_d;

  assign ten_nz     = |tens_q;
  assign five_nz    = |fives_q;
  assign tens_left  = tens_q;
  assign fives_left = fives_q;

  // Decrements are gated by the nonzero flags so an empty tube can never wrap.
  always_comb begin
    tens_d  = tens_q;
    fives_d = fives_q;
    if (refill) begin
      tens_d  = CNT_W'(INIT_TEN);
      fives_d = CNT_W'(INIT_FIVE);
    end else begin
      if (dec_ten && ten_nz)   tens_d  = tens_q - CNT_W'(1);
      if (dec_five && five_nz) fives_d = fives_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tens_q  <= CNT_W'(INIT_TEN);
      fives_q <= CNT_W'(INIT_FIVE);
    end else begin
      tens_q  <= tens_d;
      fives_q <= fives_d;
    end
  end

endmodule

// File: rtl/vending_change_dispenser.sv
// rtl/vending_change_dispenser.sv - pays change as 10/5 coins through a per-coin hopper handshake
module vending_change_dispenser
  import vending_pkg::*;
#(
  parameter int INIT_TEN  = 8,
  parameter int INIT_FIVE = 8,
  parameter int CNT_W     = 4
) (
  input logic                       clk,
  input logic                       rst,
  vending_change_dispenser_if.slave bus
);

  disp_state_e         state_q, state_d;
  logic [CHANGE_W-1:0] remaining_q, remaining_d;
  logic [CHANGE_W-1:0] shortfall_q, shortfall_d;
  logic                err_q, err_d;
  logic                sel_ten_q, sel_ten_d;
  logic                dec_ten, dec_five;
  logic                ten_nz, five_nz;
  logic                change_bad;

  assign change_bad = (bus.change % COIN_FIVE) != '0;

  vending_coin_store #(
    .INIT_TEN  (INIT_TEN),
    .INIT_FIVE (INIT_FIVE),
    .CNT_W     (CNT_W)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .refill     (bus.refill && (state_q == ST_IDLE)),
    .dec_ten    (dec_ten),
    .dec_five   (dec_five),
    .tens_left  (bus.tens_left),
    .fives_left (bus.fives_left),
    .ten_nz     (ten_nz),
    .five_nz    (five_nz)
  );

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    shortfall_d = shortfall_q;
    err_d       = err_q;
    sel_ten_d   = sel_ten_q;
    dec_ten     = 1'b0;
    dec_five    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.change_valid) begin
          remaining_d = bus.change;
          shortfall_d = bus.change;
          err_d       = change_bad;
          state_d     = change_bad ? ST_DONE : ST_SELECT;
        end
      end
      ST_SELECT: begin
        // Largest coin first; fall back to fives once tens are exhausted.
        if (remaining_q >= COIN_TEN && ten_nz) begin
          sel_ten_d = 1'b1;
          state_d   = ST_WAIT_ACK;
        end else if (remaining_q >= COIN_FIVE && five_nz) begin
          sel_ten_d = 1'b0;
          state_d   = ST_WAIT_ACK;
        end else begin
          shortfall_d = remaining_q;
          state_d     = ST_DONE;
        end
      end
      ST_WAIT_ACK: begin
        if (bus.coin_ack) begin
          remaining_d = remaining_q - (sel_ten_q ? COIN_TEN : COIN_FIVE);
          dec_ten     = sel_ten_q;
          dec_five    = !sel_ten_q;
          state_d     = ST_SELECT;
        end
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      remaining_q <= '0;
      shortfall_q <= '0;
      err_q       <= 1'b0;
      sel_ten_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      shortfall_q <= shortfall_d;
      err_q       <= err_d;
      sel_ten_q   <= sel_ten_d;
    end
  end

  assign bus.ready     = (state_q == ST_IDLE);
  assign bus.coin_ten  = (state_q == ST_WAIT_ACK) && sel_ten_q;
  assign bus.coin_five = (state_q == ST_WAIT_ACK) && !sel_ten_q;
  assign bus.done      = (state_q == ST_DONE);
  assign bus.err       = (state_q == ST_DONE) && err_q;
  assign bus.shortfall = (state_q == ST_DONE) ? shortfall_q : '0;

endmodule

// File: tb/tb_vending_change_dispenser.sv
// tb/tb_vending_change_dispenser.sv - randomized bench with a per-cycle trace model of the dispenser
module tb_vending_change_dispenser;
  import vending_pkg::*;

  localparam int CNT_W     = 4;
  localparam int INIT_TEN  = 8;
  localparam int INIT_FIVE = 8;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  vending_change_dispenser_if #(.CNT_W(CNT_W)) bus ();

  vending_change_dispenser #(
    .INIT_TEN  (INIT_TEN),
    .INIT_FIVE (INIT_FIVE),
    .CNT_W     (CNT_W)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit         rdy, ct, cf, dn, er;
    logic [4:0] sf;
    int         tl, fl;
    bit         v, rf, ak;
    logic [4:0] chg;
  } cyc_t;

  cyc_t trace[$];
  cyc_t cur;
  int   m_ten = INIT_TEN;
  int   m_five = INIT_FIVE;
  int   total = 0;
  int   bad = 0;
  bit   chk_en = 1'b0;
  int   cyc_no = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // One expected cycle; busy cycles get ignored-input noise layered on top.
  task automatic push(input bit rdy, ct, cf, dn, er, input logic [4:0] sf,
                      input bit v, rf, ak, input logic [4:0] chg);
    cyc_t e;
    e.rdy = rdy; e.ct = ct; e.cf = cf; e.dn = dn; e.er = er; e.sf = sf;
    e.tl = m_ten; e.fl = m_five; e.v = v; e.rf = rf; e.ak = ak; e.chg = chg;
    if (!rdy) begin
      if (!(ct || cf)) e.ak = ($urandom_range(0, 2) == 0);
      e.v   = ($urandom_range(0, 2) == 0);
      e.chg = 5'd25;
      e.rf  = ($urandom_range(0, 2) == 0);
    end
    trace.push_back(e);
  endtask

  task automatic push_idle(input bit rf);
    push(1, 0, 0, 0, 0, 5'd0, 0, rf, 0, 5'd0);
    if (rf) begin m_ten = INIT_TEN; m_five = INIT_FIVE; end
  endtask

  // Greedy payout computed arithmetically, then unrolled into a cycle trace.
  task automatic model_req(input int c, input bit rf, input int mind, input int maxd,
                           output int done_at, output int sf_o);
    int n10, n5, rem, d, n;
    bit ten;
    push(1, 0, 0, 0, 0, 5'd0, 1, rf, 0, 5'(c));
    if (rf) begin m_ten = INIT_TEN; m_five = INIT_FIVE; end
    if (c % 5 != 0) begin
      push(0, 0, 0, 1, 1, 5'(c), 0, 0, 0, 5'd0);
      done_at = 1;
      sf_o = c;
      return;
    end
    n10  = (c / 10 < m_ten) ? c / 10 : m_ten;
    rem  = c - 10 * n10;
    n5   = (rem / 5 < m_five) ? rem / 5 : m_five;
    sf_o = rem - 5 * n5;
    push(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0);
    n = 1;
    for (int i = 0; i < n10 + n5; i++) begin
      ten = (i < n10);
      d = $urandom_range(maxd, mind);
      for (int j = 0; j <= d; j++) begin
        push(0, ten, !ten, 0, 0, 5'd0, 0, 0, (j == d), 5'd0);
        n++;
      end
      if (ten) m_ten--; else m_five--;
      push(0, 0, 0, 0, 0, 5'd0, 0, 0, 0, 5'd0);
      n++;
    end
    push(0, 0, 0, 1, 0, 5'(sf_o), 0, 0, 0, 5'd0);
    n++;
    done_at = n;
  endtask

  task automatic run_trace();
    while (trace.size() > 0) begin
      @(posedge clk); #1;
      cur = trace.pop_front();
      bus.change_valid = cur.v;
      bus.change       = cur.chg;
      bus.refill       = cur.rf;
      bus.coin_ack     = cur.ak;
      chk_en = 1'b1;
    end
    @(negedge clk); #1;
    chk_en = 1'b0;
    bus.change_valid = 1'b0;
    bus.refill       = 1'b0;
    bus.coin_ack     = 1'b0;
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cyc_no++;
      check($sformatf("cycle%0d_outputs", cyc_no),
            {14'd0, bus.ready, bus.coin_ten, bus.coin_five, bus.done, bus.err,
             bus.shortfall, bus.tens_left, bus.fives_left},
            {14'd0, cur.rdy, cur.ct, cur.cf, cur.dn, cur.er, cur.sf,
             CNT_W'(cur.tl), CNT_W'(cur.fl)});
    end
  end

  initial begin
    int da, sf, c;
    bus.change = '0; bus.change_valid = 1'b0; bus.coin_ack = 1'b0; bus.refill = 1'b0;
    #12;
    check("reset_outputs",
          {bus.ready, bus.coin_ten, bus.coin_five, bus.done, bus.err, bus.shortfall},
          {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
    check("reset_tens", bus.tens_left, 4'd8);
    check("reset_fives", bus.fives_left, 4'd8);
    @(negedge clk); rst = 1'b1;

    model_req(15, 0, 0, 0, da, sf);
    check("pin_done15", da, 6);
    run_trace();
    check("pin_tens15", bus.tens_left, 4'd7);
    check("pin_fives15", bus.fives_left, 4'd7);

    model_req(7, 0, 0, 0, da, sf);
    check("pin_err7_cycle", da, 1);
    check("pin_err7_short", sf, 7);
    model_req(0, 0, 0, 0, da, sf);
    check("pin_zero_cycle", da, 2);
    model_req(30, 0, 0, 1, da, sf);
    model_req(30, 0, 0, 1, da, sf);
    model_req(20, 0, 0, 0, da, sf);
    check("pin_20a_cycle", da, 8);
    model_req(20, 0, 0, 0, da, sf);
    check("pin_20b_short", sf, 0);
    model_req(10, 0, 0, 0, da, sf);
    check("pin_10_short", sf, 5);
    run_trace();
    check("pin_tens_empty", bus.tens_left, 4'd0);
    check("pin_fives_empty", bus.fives_left, 4'd0);

    push_idle(1);
    model_req(10, 0, 3, 3, da, sf);
    check("pin_delay_done", da, 7);
    model_req(31, 0, 0, 0, da, sf);
    run_trace();

    for (int r = 0; r < 40; r++) begin
      for (int k = $urandom_range(0, 2); k > 0; k--) push_idle($urandom_range(0, 5) == 0);
      c = ($urandom_range(0, 4) == 0) ? $urandom_range(0, 31) : 5 * $urandom_range(0, 6);
      model_req(c, $urandom_range(0, 6) == 0, 0, 2, da, sf);
      run_trace();
    end

    push_idle(1);
    model_req(10, 0, 0, 0, da, sf);
    run_trace();
    @(posedge clk); #1;
    bus.change_valid = 1'b1; bus.change = 5'd10;
    @(posedge clk); #1;
    bus.change_valid = 1'b0;
    @(posedge clk); #1;
    check("wait_coin_before_rst", bus.coin_ten, 1'b1);
    #2 rst = 1'b0;
    #1;
    check("rst_coin_drop", {bus.coin_ten, bus.coin_five}, 2'b00);
    check("rst_tens_init", bus.tens_left, 4'd8);
    check("rst_ready", bus.ready, 1'b1);
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("post_rst_idle", {bus.ready, bus.done, bus.coin_ten, bus.coin_five}, 4'b1000);
    end
    m_ten = INIT_TEN; m_five = INIT_FIVE;
    model_req(25, 0, 0, 2, da, sf);
    run_trace();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vending_change_dispenser.md
# vending_change_dispenser

Change pay-out unit on the output side of the ticket vending machine: it takes the change amount the vending FSM computes after a sale and drops it as physical 10- and 5-unit coins through a coin hopper with a per-coin handshake. It tracks its own coin inventory, falls back to 5s when 10s run out, and reports any amount it could not pay. It sits between the vending FSM's `change` output and the hopper driver.

## Interface
Parameters:
- `INIT_TEN`, 8: number of 10-unit coins after reset or refill.
- `INIT_FIVE`, 8: number of 5-unit coins after reset or refill.
- `CNT_W`, 4: width of the inventory counters. `INIT_*` must be less than 2^CNT_W.

Ports:
- `clk`  in  1: single clock; all state changes on the rising edge.
- `rst`  in  1: asynchronous, active-low reset.
- `change`  in  5: change owed, in currency units; sampled with `change_valid`.
- `change_valid`  in  1: one-cycle request strobe; accepted only while `ready`=1.
- `ready`  out  1: idle and able to accept a request.
- `coin_ten`  out  1: drop-a-10 command, held until `coin_ack`.
- `coin_five`  out  1: drop-a-5 command, held until `coin_ack`.
- `coin_ack`  in  1: hopper confirms the commanded coin dropped.
- `refill`  in  1: reload both inventories to the `INIT_*` values.
- `done`  out  1: one-cycle pulse when a request completes.
- `shortfall`  out  5: amount left unpaid; valid while `done`=1, 0 otherwise.
- `err`  out  1: pulses with `done` when `change` is not a multiple of 5.
- `tens_left`  out  CNT_W: current 10-coin inventory.
- `fives_left`  out  CNT_W: current 5-coin inventory.

## Operation
- Reset values:
  - `ready`=1.
  - `coin_ten`=`coin_five`=`done`=`err`=0, `shortfall`=0.
  - `tens_left`=`INIT_TEN`, `fives_left`=`INIT_FIVE`.
  - FSM in IDLE; the remaining-amount register is 0.
- FSM states: IDLE, SELECT, WAIT_ACK, DONE. All outputs are Moore, decoded from registered state.
- IDLE:
  - On `change_valid`, latch `change` into `remaining`.
  - If `change` mod 5 ≠ 0, go to DONE with `err` set and `shortfall`=`change`; no coins are dropped.
  - Otherwise go to SELECT.
- SELECT, evaluated in priority order:
  1. If `remaining`≥10 and `tens_left`>0: choose ten and go to WAIT_ACK.
  2. Else if `remaining`≥5 and `fives_left`>0: choose five and go to WAIT_ACK.
  3. Else go to DONE with `shortfall`=`remaining`.
- WAIT_ACK:
  - `coin_ten` or `coin_five` (only the chosen one) is high for the whole state.
  - On `coin_ack`: subtract the coin value from `remaining`, decrement the matching inventory, and return to SELECT.
  - The coin line drops on the same edge.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- Arithmetic: `remaining` is 5-bit unsigned. The guards in SELECT make underflow impossible. Inventory counters never decrement below 0.
- `change`=0: passes through SELECT to DONE with `shortfall`=0.
- `change_valid` outside IDLE is ignored, not queued.
- `coin_ack` outside WAIT_ACK is ignored.
- `refill` takes effect only in IDLE and is ignored in other states. If `refill` and `change_valid` arrive in the same IDLE cycle, both happen and SELECT sees the reloaded counts.
- `rst` asserted mid-request:
  - Coin lines drop immediately (asynchronous reset).
  - The pending request is discarded.
  - Inventories return to `INIT_*`.

## Timing
- Request accepted at edge 0:
  - SELECT in cycle 1.
  - First coin line high from cycle 2.
- With `coin_ack` arriving in the first WAIT_ACK cycle, each coin costs 2 cycles. `done` is high in cycle 2k+2 for k coins.
- Each cycle of `coin_ack` delay adds one cycle.
- Error path: `done` and `err` are high in cycle 1.
- `ready` returns to 1 the cycle after `done`.
- Throughput: a back-to-back request can be accepted in the first `ready` cycle.

## Structure
- Shared `vending_pkg` holds:
  - the FSM state enum;
  - `COIN_TEN`=10 and `COIN_FIVE`=5;
  - `CHANGE_W`=5, shared with the vending FSM's `change` output.
- One natural sub-module, `vending_coin_store`, holds:
  - the two inventory down-counters with refill;
  - decrement-by-select;
  - the nonzero flags.
- The FSM and `remaining` stay in the top module.

## Test plan
- Defaults, `change`=15, `coin_ack` tied to the OR of the coin lines:
  - `coin_ten` high in cycle 2, `coin_five` high in cycle 4.
  - `done` in cycle 6 with `shortfall`=0.
  - `tens_left`=7, `fives_left`=7.
- `INIT_TEN`=1, `change`=20, then `change`=20 again:
  - First request: ten, five, five.
  - Second request: four fives.
  - Both end with `shortfall`=0, `tens_left`=0, `fives_left`=2.
- `INIT_TEN`=0, `INIT_FIVE`=1, `change`=10:
  - One five dropped.
  - `done` with `shortfall`=5.
  - `fives_left`=0.
- `change`=7:
  - `done` and `err` in cycle 1, `shortfall`=7.
  - No coin line ever high; inventories unchanged.
- `change`=10 with `coin_ack` delayed 3 cycles:
  - `coin_ten` held for 4 cycles.
  - A second `change_valid`=25 during WAIT_ACK is ignored.
  - `done` in cycle 7.
- `rst` low during WAIT_ACK:
  - Coin line 0 with no clock edge.
  - After release: `ready`=1, inventories at `INIT_*`, `done` never pulses.
  - A `refill` during WAIT_ACK in a separate run leaves the counts unchanged.
